// File: rtl/sram_one_port_arbiter_if.sv
// Requester, read-return and SRAM-side signals of the one-port SRAM arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface sram_one_port_arbiter_if #(
    parameter int unsigned BW    = 8,
    parameter int unsigned NDATA = 16
);
    localparam int unsigned AW = (NDATA > 1) ? $clog2(NDATA) : 1;

    logic          i_w_valid;
    logic          o_w_ready;
    logic [AW-1:0] i_w_addr;
    logic [BW-1:0] i_w_data;

    logic          i_r_valid;
    logic          o_r_ready;
    logic [AW-1:0] i_r_addr;

    logic          o_rd_valid;
    logic          i_rd_ready;
    logic [BW-1:0] o_rd_data;

    logic          o_sram_ce;
    logic          o_sram_r0w1;
    logic [AW-1:0] o_sram_addr;
    logic [BW-1:0] o_sram_wdata;
    logic [BW-1:0] i_sram_rdata;

    modport slave (
        input  i_w_valid, i_w_addr, i_w_data,
        input  i_r_valid, i_r_addr,
        input  i_rd_ready, i_sram_rdata,
        output o_w_ready, o_r_ready,
        output o_rd_valid, o_rd_data,
        output o_sram_ce, o_sram_r0w1, o_sram_addr, o_sram_wdata
    );

    modport master (
        output i_w_valid, i_w_addr, i_w_data,
        output i_r_valid, i_r_addr,
        output i_rd_ready, i_sram_rdata,
        input  o_w_ready, o_r_ready,
        input  o_rd_valid, o_rd_data,
        input  o_sram_ce, o_sram_r0w1, o_sram_addr, o_sram_wdata
    );
endinterface

// File: rtl/sram_one_port_arbiter.sv
// Arbitrates one write and one read requester onto a single-port SRAM,
// returning read data through a 3-entry FIFO with credit-based flow control.
module sram_one_port_arbiter #(
    parameter int unsigned BW    = 8,
    parameter int unsigned NDATA = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    sram_one_port_arbiter_if.slave bus
);
    localparam int unsigned AW    = (NDATA > 1) ? $clog2(NDATA) : 1;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned PW    = 2;
    localparam int unsigned OW    = 3;

    logic [PW-1:0] r_count;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic          r_infl;
    logic          r_prio;
    logic [BW-1:0] r_mem [DEPTH];

    logic [OW-1:0] w_outstanding;
    logic          w_w_elig;
    logic          w_r_elig;
    logic          w_grant_w;
    logic          w_grant_r;
    logic          w_rd_valid;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Reads in flight plus buffered reads form the credit count against FIFO depth.
    always_comb begin
        w_outstanding = OW'(r_count) + OW'(r_infl);
        w_w_elig      = bus.i_w_valid;
        w_r_elig      = bus.i_r_valid && (w_outstanding < OW'(DEPTH));
        w_grant_w     = 1'b0;
        w_grant_r     = 1'b0;
        if (!i_rst) begin
            if (w_w_elig && w_r_elig) begin
                w_grant_w = !r_prio;
                w_grant_r = r_prio;
            end else begin
                w_grant_w = w_w_elig;
                w_grant_r = w_r_elig;
            end
        end
    end

    assign w_rd_valid = !i_rst && (r_count != '0);
    assign w_push     = r_infl;
    assign w_pop      = w_rd_valid && bus.i_rd_ready;

    assign bus.o_w_ready    = w_grant_w;
    assign bus.o_r_ready    = w_grant_r;
    assign bus.o_sram_ce    = w_grant_w | w_grant_r;
    assign bus.o_sram_r0w1  = w_grant_w;
    assign bus.o_sram_addr  = w_grant_w ? bus.i_w_addr : bus.i_r_addr;
    assign bus.o_sram_wdata = bus.i_w_data;
    assign bus.o_rd_valid   = w_rd_valid;
    assign bus.o_rd_data    = r_mem[r_rptr];

    // Control state; reset drops any read still in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_infl  <= 1'b0;
            r_prio  <= 1'b0;
        end else begin
            r_infl <= w_grant_r;
            if (w_grant_w) begin
                r_prio <= 1'b1;
            end else if (w_grant_r) begin
                r_prio <= 1'b0;
            end
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + PW'(1);
                2'b01:   r_count <= r_count - PW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push) begin
            r_mem[r_wptr] <= bus.i_sram_rdata;
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, AW[0]};
endmodule

// File: doc/sram_one_port_arbiter.md
SRAM_ONE_PORT_ARBITER -- requirements
Module: sram_one_port_arbiter

Interface
REQ-001 SHALL have parameter BW, default 8, data width in bits.
REQ-002 SHALL have parameter NDATA, default 16, SRAM depth in words; address width AW = $clog2(NDATA).
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have ports i_w_valid (input, 1), o_w_ready (output, 1), i_w_addr (input, AW) and i_w_data (input, BW), the write requester; transfer when valid && ready.
REQ-006 SHALL have ports i_r_valid (input, 1), o_r_ready (output, 1) and i_r_addr (input, AW), the read requester; transfer when valid && ready.
REQ-007 SHALL have ports o_rd_valid (output, 1), i_rd_ready (input, 1) and o_rd_data (output, BW), the read-data return; pop when valid && ready.
REQ-008 SHALL have ports o_sram_ce (output, 1), o_sram_r0w1 (output, 1, 0 = read, 1 = write), o_sram_addr (output, AW) and o_sram_wdata (output, BW), driving one single-port SRAM.
REQ-009 SHALL have port i_sram_rdata, input, BW, SRAM read data, valid the cycle after a read is issued.

Function
REQ-010 SHALL issue at most one SRAM access per cycle; o_sram_ce = o_w_ready | o_r_ready, and o_w_ready and o_r_ready SHALL never both be 1.
REQ-011 SHALL hold a 3-entry read-data FIFO (count_r, 0..3) and a 1-bit in-flight flag (infl_r), set the cycle after a read grant.
REQ-012 SHALL make the read eligible iff i_r_valid && (count_r + infl_r < 3), using registered values only; the write is eligible iff i_w_valid.
REQ-013 SHALL grant combinationally: if exactly one requester is eligible it is granted; if both are eligible the requester selected by priority bit prio_r is granted (prio_r = 0 grants W, prio_r = 1 grants R).
REQ-014 SHALL update prio_r after every grant to favour the other requester (W grant sets prio_r = 1, R grant sets prio_r = 0); prio_r SHALL hold when there is no grant.
REQ-015 SHALL, on a W grant, drive o_sram_r0w1 = 1, o_sram_addr = i_w_addr and o_sram_wdata = i_w_data in the same cycle.
REQ-016 SHALL, on an R grant, drive o_sram_r0w1 = 0 and o_sram_addr = i_r_addr; o_sram_wdata is don't-care.
REQ-017 SHALL, when there is no grant, hold o_sram_ce = 0, with o_sram_r0w1, o_sram_addr and o_sram_wdata don't-care.
REQ-018 SHALL push i_sram_rdata into the FIFO on the cycle infl_r = 1; read latency is grant in cycle t, data pushed at the end of t+1, o_rd_valid high from t+2.
REQ-019 SHALL drive o_rd_valid = (count_r != 0) and o_rd_data = FIFO head, stable while o_rd_valid && !i_rd_ready.
REQ-020 SHALL handle a simultaneous push and pop by leaving count_r unchanged, with FIFO order preserved.
REQ-021 SHALL never push when count_r = 3; REQ-012 guarantees this and the bench SHALL assert it.
REQ-022 SHALL use 2-bit FIFO read/write pointers wrapping 2 -> 0.
REQ-023 SHALL sustain one read per cycle when i_rd_ready is held at 1.
REQ-024 SHALL complete transfers in grant order; a write granted before a read to the same address SHALL be visible to that read.

Reset
REQ-025 SHALL, while i_rst = 1 at a clock edge, clear count_r, infl_r, FIFO pointers and prio_r to 0.
REQ-026 SHALL force o_w_ready = 0, o_r_ready = 0, o_sram_ce = 0 and o_rd_valid = 0 during any cycle in which i_rst = 1, regardless of requests.
REQ-027 SHALL discard a read in flight when reset is asserted mid-operation; its data SHALL NOT appear after reset.

Verification
REQ-028 SHALL cover single write then read: W(addr 5, 0xA5) granted in cycle 0; R(addr 5) granted in cycle 1 -> o_rd_valid = 1 with o_rd_data = 0xA5 in cycle 3.
REQ-029 SHALL cover contention: both requesters valid continuously after reset -> grants alternate W, R, W, R, ..., with no cycle in which both ready signals are high.
REQ-030 SHALL cover backpressure: i_rd_ready = 0 with reads to addresses 0..4 -> exactly 3 reads granted, o_r_ready held 0 after that; raising i_rd_ready -> data for addresses 0..4 returned in order.
REQ-031 SHALL cover streaming: i_rd_ready = 1 with 8 back-to-back reads and no writes -> 8 consecutive read grants and 8 consecutive o_rd_valid cycles beginning 2 cycles after the first grant.
REQ-032 SHALL cover reset mid-read: R granted in cycle t, i_rst = 1 in cycle t+1 -> o_rd_valid = 0 and count_r = 0 after reset, with no stale data popped.
